// File: rtl/rotor_stack_stepper_pkg.sv
// rotor_stack_pkg: shared constants for the rotor stack stepper.
//   - ALPHA_DEFAULT      : default alphabet size (26 letters)
//   - state_e            : stepper FSM states
//   - WIRING / WIRING_INV: rotor I, II, III permutations and their inverses
//   - WIRING_NOTCH       : turnover position of each wiring
//   - REFL_B             : reflector B permutation
//   - ROTOR_SEL          : wiring used at each stack index (0 = fast rotor)
package rotor_stack_pkg;

  localparam int ALPHA_DEFAULT = 26;
  localparam int NUM_WIRINGS   = 3;
  localparam int MAX_ROTORS    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    ENCODE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Index 0 = rotor I, 1 = rotor II, 2 = rotor III.
  localparam int WIRING [NUM_WIRINGS][ALPHA_DEFAULT] = '{
    '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14, 22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9},
    '{0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22, 19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4},
    '{1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25, 13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14}
  };

  localparam int WIRING_INV [NUM_WIRINGS][ALPHA_DEFAULT] = '{
    '{20, 22, 24, 6, 0, 3, 5, 15, 21, 25, 1, 4, 2, 10, 12, 19, 7, 23, 18, 11, 17, 8, 13, 16, 14, 9},
    '{0, 9, 15, 2, 25, 22, 17, 11, 5, 1, 3, 10, 14, 19, 24, 20, 16, 6, 4, 13, 7, 23, 12, 8, 21, 18},
    '{19, 0, 6, 1, 15, 2, 18, 3, 16, 4, 20, 5, 21, 13, 25, 7, 24, 8, 23, 9, 22, 11, 17, 10, 14, 12}
  };

  localparam int WIRING_NOTCH [NUM_WIRINGS] = '{16, 4, 21};

  localparam int REFL_B [ALPHA_DEFAULT] = '{
    24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14, 10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19
  };

  // Classic III-II-I stack for the first three slots; deeper stacks cycle the set.
  localparam int ROTOR_SEL [MAX_ROTORS] = '{2, 1, 0, 2, 1, 0, 2, 1};

endpackage

// File: rtl/rotor_stack_stepper_if.sv
// rotor_stack_stepper_if: handshake bundle between keyboard scanner, stepper and lampboard.
//   Input side : IN_VALID, IN_READY, IN_LETTER (one-hot), LOAD, LOAD_POS
//   Output side: OUT_VALID, OUT_READY, OUT_LETTER (one-hot), OUT_ERR
//   Status     : POS (registered rotor positions, rotor i at [i*PW +: PW])
//   master = producer/consumer around the block, slave = the stepper itself.
interface rotor_stack_stepper_if
  import rotor_stack_pkg::*;
#(
  parameter int ALPHA      = ALPHA_DEFAULT,
  parameter int NUM_ROTORS = 3,
  parameter int PW         = $clog2(ALPHA)
);
  logic                     IN_VALID;
  logic                     IN_READY;
  logic [ALPHA-1:0]         IN_LETTER;
  logic                     LOAD;
  logic [NUM_ROTORS*PW-1:0] LOAD_POS;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic [ALPHA-1:0]         OUT_LETTER;
  logic                     OUT_ERR;
  logic [NUM_ROTORS*PW-1:0] POS;

  modport master (
    output IN_VALID, IN_LETTER, LOAD, LOAD_POS, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_LETTER, OUT_ERR, POS
  );

  modport slave (
    input  IN_VALID, IN_LETTER, LOAD, LOAD_POS, OUT_READY,
    output IN_READY, OUT_VALID, OUT_LETTER, OUT_ERR, POS
  );
endinterface

// File: rtl/rotor_stack_stepper_perm_stage.sv
// rotor_perm_stage: combinational pass of a one-hot letter through one rotor.
//   letter_i  : one-hot input letter
//   pos_i     : rotor position (0..ALPHA-1)
//   inverse_i : 0 = forward wiring, 1 = inverse wiring (return path)
//   letter_o  : one-hot output letter
// Computes y = (T[(x + p) mod ALPHA] - p) mod ALPHA with T = WIRING or WIRING_INV.
module rotor_perm_stage
  import rotor_stack_pkg::*;
#(
  parameter int ALPHA     = ALPHA_DEFAULT,
  parameter int PW        = $clog2(ALPHA),
  parameter int WIRING_ID = 0
) (
  input  logic [ALPHA-1:0] letter_i,
  input  logic [PW-1:0]    pos_i,
  input  logic             inverse_i,
  output logic [ALPHA-1:0] letter_o
);
  localparam int XW = PW + 1;

  logic [XW-1:0] x, shifted, mapped, y;

  always_comb begin
    x = '0;
    for (int k = 0; k < ALPHA; k++)
      if (letter_i[k]) x = x | XW'(k);

    // x, p < ALPHA so one conditional subtract is a full mod.
    shifted = x + {1'b0, pos_i};
    if (shifted >= XW'(ALPHA)) shifted = shifted - XW'(ALPHA);

    mapped = '0;
    for (int k = 0; k < ALPHA; k++)
      if (shifted == XW'(k))
        mapped = inverse_i ? XW'(WIRING_INV[WIRING_ID][k]) : XW'(WIRING[WIRING_ID][k]);

    // Adding ALPHA before subtracting p keeps the difference non-negative.
    y = mapped + XW'(ALPHA) - {1'b0, pos_i};
    if (y >= XW'(ALPHA)) y = y - XW'(ALPHA);

    letter_o = '0;
    for (int k = 0; k < ALPHA; k++)
      letter_o[k] = (y == XW'(k));
  end
endmodule

// File: rtl/rotor_stack_stepper.sv
// rotor_stack_stepper: clocked rotor stack with odometer stepping and double-step.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus.slave  : IN_VALID/IN_READY/IN_LETTER/LOAD/LOAD_POS in,
//                OUT_VALID/OUT_READY/OUT_LETTER/OUT_ERR out, POS status.
// Flow per letter: IDLE (accept) -> STEP (advance rotors) -> ENCODE (register
// result of the forward/reflector/inverse chain) -> HOLD (until OUT_READY).
module rotor_stack_stepper
  import rotor_stack_pkg::*;
#(
  parameter int ALPHA      = ALPHA_DEFAULT,
  parameter int NUM_ROTORS = 3,
  parameter int PW         = $clog2(ALPHA)
) (
  input  logic CLK,
  input  logic RST_N,
  rotor_stack_stepper_if.slave bus
);
  localparam int PBITS = NUM_ROTORS * PW;

  state_e           state_q, state_d;
  logic [PBITS-1:0] pos_q, pos_d;
  logic [ALPHA-1:0] letter_q, letter_d;
  logic             bad_q, bad_d;
  logic [ALPHA-1:0] out_letter_q, out_letter_d;
  logic             out_err_q, out_err_d;

  logic [PW-1:0]         cur [NUM_ROTORS];
  logic [NUM_ROTORS-1:0] step_en;
  logic [PBITS-1:0]      pos_stepped, pos_loaded;
  logic                  in_onehot;
  logic [ALPHA-1:0]      fwd [NUM_ROTORS+1];
  logic [ALPHA-1:0]      bwd [NUM_ROTORS+1];

  assign in_onehot = (bus.IN_LETTER != '0) &&
                     ((bus.IN_LETTER & (bus.IN_LETTER - ALPHA'(1))) == '0);

  // Step enables come from pre-step positions; a middle rotor sitting on its
  // notch carries the next rotor and also advances itself (double-step).
  always_comb begin
    step_en    = '0;
    step_en[0] = 1'b1;
    for (int i = 0; i < NUM_ROTORS; i++) cur[i] = pos_q[i*PW +: PW];
    for (int i = 0; i < NUM_ROTORS - 1; i++) begin
      if (cur[i] == PW'(WIRING_NOTCH[ROTOR_SEL[i]])) begin
        step_en[i+1] = 1'b1;
        if (i >= 1) step_en[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (!step_en[i])                  pos_stepped[i*PW +: PW] = cur[i];
      else if (cur[i] == PW'(ALPHA-1))  pos_stepped[i*PW +: PW] = '0;
      else                              pos_stepped[i*PW +: PW] = cur[i] + PW'(1);
    end
  end

  // A PW-bit field is below 2*ALPHA, so one subtract reduces it mod ALPHA.
  always_comb begin
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if ({1'b0, bus.LOAD_POS[i*PW +: PW]} >= (PW+1)'(ALPHA))
        pos_loaded[i*PW +: PW] = PW'({1'b0, bus.LOAD_POS[i*PW +: PW]} - (PW+1)'(ALPHA));
      else
        pos_loaded[i*PW +: PW] = bus.LOAD_POS[i*PW +: PW];
    end
  end

  assign fwd[0] = letter_q;

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_fwd
    rotor_perm_stage #(.ALPHA(ALPHA), .PW(PW), .WIRING_ID(ROTOR_SEL[g])) u_stage (
      .letter_i  (fwd[g]),
      .pos_i     (pos_q[g*PW +: PW]),
      .inverse_i (1'b0),
      .letter_o  (fwd[g+1])
    );
  end

  always_comb begin
    bwd[NUM_ROTORS] = '0;
    for (int k = 0; k < ALPHA; k++)
      bwd[NUM_ROTORS][REFL_B[k]] = bwd[NUM_ROTORS][REFL_B[k]] | fwd[NUM_ROTORS][k];
  end

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_bwd
    rotor_perm_stage #(.ALPHA(ALPHA), .PW(PW), .WIRING_ID(ROTOR_SEL[g])) u_stage (
      .letter_i  (bwd[g+1]),
      .pos_i     (pos_q[g*PW +: PW]),
      .inverse_i (1'b1),
      .letter_o  (bwd[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    letter_d     = letter_q;
    bad_d        = bad_q;
    out_letter_d = out_letter_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.LOAD) begin
          pos_d = pos_loaded;
        end else if (bus.IN_VALID) begin
          letter_d = bus.IN_LETTER;
          bad_d    = !in_onehot;
          state_d  = STEP;
        end
      end
      STEP: begin
        if (!bad_q) pos_d = pos_stepped;
        state_d = ENCODE;
      end
      ENCODE: begin
        out_letter_d = bad_q ? '0 : bwd[0];
        out_err_d    = bad_q;
        state_d      = HOLD;
      end
      HOLD: begin
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      letter_q     <= '0;
      bad_q        <= 1'b0;
      out_letter_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      letter_q     <= letter_d;
      bad_q        <= bad_d;
      out_letter_q <= out_letter_d;
      out_err_q    <= out_err_d;
    end
  end

  // IN_READY is gated by reset so the block never advertises space while held.
  assign bus.IN_READY   = RST_N && (state_q == IDLE);
  assign bus.OUT_VALID  = (state_q == HOLD);
  assign bus.OUT_LETTER = out_letter_q;
  assign bus.OUT_ERR    = out_err_q;
  assign bus.POS        = pos_q;
endmodule
